// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: the receive-FIFO entry layout and its default depth.
package uart_defs;

    typedef struct packed {
        logic       frame_err;
        logic       parity_err;
        logic [7:0] data;
    } RxEntry_t;

    localparam int UART_RX_FIFO_DEPTH = 16;

    function automatic logic [1:0] rx_entry_err(input RxEntry_t e);
        return {e.frame_err, e.parity_err};
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Register-array storage for the RX FIFO: one synchronous write port, one
// asynchronous read port, no reset on the contents.
module uart_fifo_ram
    import uart_defs::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  RxEntry_t                 wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output RxEntry_t                 rdata_o
);

    RxEntry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer with per-byte error flags, hysteretic RTS,
// level-threshold interrupt and sticky overrun flag.
module uart_rx_fifo
    import uart_defs::*;
#(
    parameter int DEPTH      = UART_RX_FIFO_DEPTH,
    parameter int RTS_MARGIN = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic [7:0]             in_d_i,
    input  logic [1:0]             in_err_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [7:0]             out_d_o,
    output logic [1:0]             out_err_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    input  logic [$clog2(DEPTH):0] threshold_i,
    input  logic                   overrun_clr_i,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   overrun_o,
    output logic                   thresh_irq_o,
    output logic                   rts_n_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] RTS_HI  = PW'(DEPTH - RTS_MARGIN);
    localparam logic [PW-1:0] RTS_LO  = PW'(DEPTH / 2);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic          overrun_q, overrun_d;
    logic          rts_q, rts_d;
    logic          irq_q, irq_d;

    logic     full, empty, push, pop, ram_we;
    RxEntry_t wr_entry, rd_entry;

    // Wrap-bit pointers: equal means empty, equal low bits with differing MSB means full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Both ports are valid/ready: a transfer happens on an edge where valid and
    // ready are both high; valid never depends on ready. Full refuses pushes
    // even when a pop happens in the same cycle.
    assign push = in_valid_i && !full;
    assign pop  = out_ready_i && !empty;

    assign wr_entry = '{frame_err: in_err_i[1], parity_err: in_err_i[0], data: in_d_i};
    assign ram_we   = push && !flush_i;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = overrun_q;
        rts_d     = rts_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        level_d = wr_ptr_d - rd_ptr_d;

        // Set beats clear when both arrive together.
        if (overrun_clr_i)       overrun_d = 1'b0;
        if (in_valid_i && full)  overrun_d = 1'b1;

        if (level_d >= RTS_HI)      rts_d = 1'b1;
        else if (level_d <= RTS_LO) rts_d = 1'b0;

        irq_d = (threshold_i != '0) && (level_d >= threshold_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
            rts_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
            rts_q     <= rts_d;
            irq_q     <= irq_d;
        end
    end

    uart_fifo_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk    (clk),
        .we_i   (ram_we),
        .waddr_i(wr_ptr_q[AW-1:0]),
        .wdata_i(wr_entry),
        .raddr_i(rd_ptr_q[AW-1:0]),
        .rdata_o(rd_entry)
    );

    // Head is masked while empty so unreset storage never reaches the outputs.
    assign out_d_o      = empty ? 8'h00 : rd_entry.data;
    assign out_err_o    = empty ? 2'b00 : rx_entry_err(rd_entry);
    assign out_valid_o  = !empty;
    assign in_ready_o   = !full;
    assign level_o      = level_q;
    assign full_o       = full;
    assign empty_o      = empty;
    assign overrun_o    = overrun_q;
    assign thresh_irq_o = irq_q;
    assign rts_n_o      = rts_q;

endmodule
